// File: rtl/print_screen_pkg.sv
// Shared constants, baud divisor helper and state encodings for the print-screen UART.
package print_screen_pkg;

    localparam int PACKET_BITS  = 176;
    localparam int PACKET_BYTES = 22;

    // Integer-truncated divisor; the result must be at least 4 for the mid-bit sampler.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 receiver: two-flop synchronizer, mid-bit sampling, one-cycle valid on a good stop bit.
module uart_rx_byte
    import print_screen_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rxd,
    output logic       o_valid,
    output logic [7:0] o_data
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

    logic          r_sync1;
    logic          r_sync2;
    rx_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          w_rx;

    assign w_rx    = r_sync2;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            r_valid <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx) r_state <= RX_START;
                end
                RX_START: begin
                    if (r_cnt == CNT_MID) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        // A high level at mid start bit is a glitch, not a character.
                        r_state <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt  <= '0;
                        r_data <= {w_rx, r_data[7:1]};
                        r_bit  <= r_bit + 1'b1;
                        if (r_bit == 3'd7) r_state <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (w_rx) begin
                            r_valid <= 1'b1;
                            r_state <= RX_IDLE;
                        end else begin
                            r_state <= RX_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (w_rx) r_state <= RX_IDLE;
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/print_screen_uart.sv
// Any received byte triggers a snapshot of the 176-bit packet, sent as 22 back-to-back 8N1 bytes.
module print_screen_uart
    import print_screen_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RxD,
    output logic                   TxD,
    input  logic [PACKET_BITS-1:0] packet
);

    localparam int            CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int            CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]    BYTE_LAST    = 5'(PACKET_BYTES - 1);

    logic       w_req;
    logic [7:0] w_rx_byte_unused;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .i_rxd   (RxD),
        .o_valid (w_req),
        .o_data  (w_rx_byte_unused)
    );

    tx_state_t              r_state;
    logic [CW-1:0]          r_baud_cnt;
    logic [2:0]             r_bit_idx;
    logic [4:0]             r_byte_idx;
    logic [PACKET_BITS-1:0] r_shadow;
    logic                   r_txd;

    assign TxD = r_txd;

    // The shadow shifts right once per data bit, so the bit on the line is always r_shadow[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= TX_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shadow   <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_req) begin
                        r_shadow   <= packet;
                        r_baud_cnt <= '0;
                        r_byte_idx <= '0;
                        r_txd      <= 1'b0;
                        r_state    <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_baud_cnt == CNT_LAST) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_txd      <= r_shadow[0];
                        r_state    <= TX_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (r_baud_cnt == CNT_LAST) begin
                        r_baud_cnt <= '0;
                        r_shadow   <= r_shadow >> 1;
                        r_bit_idx  <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= TX_STOP;
                        end else begin
                            r_txd <= r_shadow[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (r_baud_cnt == CNT_LAST) begin
                        r_baud_cnt <= '0;
                        if (r_byte_idx == BYTE_LAST) begin
                            r_state <= TX_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_txd      <= 1'b0;
                            r_state    <= TX_START;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_print_screen_uart.sv
// Directed bench: drives request bytes on RxD and decodes TxD with an 8N1 monitor (16 clocks/bit).
module tb_print_screen_uart;

    localparam int CPB = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         RxD;
    logic         TxD;
    logic [175:0] packet;

    int    checks = 0;
    int    errors = 0;
    longint cyc = 0;

    logic [7:0] rx_q[$];
    longint     start_q[$];
    int         width_err = 0;

    print_screen_uart #(.CLK_HZ(16), .BAUD(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .RxD    (RxD),
        .TxD    (TxD),
        .packet (packet)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every bit must hold one level for all CPB samples; start 0, stop 1.
    initial begin : mon
        logic [9:0] bits;
        logic       s;
        forever begin
            @(negedge clk);
            if (TxD === 1'b0) begin
                start_q.push_back(cyc);
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        s = TxD;
                        if (c == 0) bits[b] = s;
                        else if (s !== bits[b]) width_err++;
                        if (!(b == 9 && c == CPB - 1)) @(negedge clk);
                    end
                end
                if (bits[0] !== 1'b0 || bits[9] !== 1'b1) width_err++;
                rx_q.push_back(bits[8:1]);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, output longint t0);
        @(negedge clk);
        t0  = cyc;
        RxD = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (CPB) @(negedge clk);
        end
        RxD = stop;
        repeat (CPB) @(negedge clk);
        RxD = 1'b1;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_count"}, 64'(rx_q.size()), 64'(n));
    endtask

    task automatic check_frame(input logic [175:0] exp, input string tag);
        for (int k = 0; k < 22; k++) begin
            if (k < rx_q.size())
                chk($sformatf("%s_b%0d", tag, k), 64'(rx_q[k]), 64'(exp[8*k +: 8]));
        end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        start_q.delete();
        width_err = 0;
    endtask

    initial begin : main
        longint       t0;
        int           lows;
        logic [175:0] pat;
        logic [175:0] exp;

        for (int k = 0; k < 22; k++) pat[8*k +: 8] = 8'(3 * k + 1);

        rst    = 1'b1;
        RxD    = 1'b1;
        packet = '0;
        repeat (5) @(negedge clk);
        chk("reset_txd", 64'(TxD), 64'd1);
        rst = 1'b0;

        // Idle line must produce nothing.
        lows = 0;
        repeat (10000) begin
            @(negedge clk);
            if (TxD !== 1'b1) lows++;
        end
        chk("idle_txd_low_cycles", 64'(lows), 64'd0);
        chk("idle_no_bytes", 64'(rx_q.size()), 64'd0);

        // Basic frame; packet is overwritten one cycle after the capture edge.
        packet = {160'h0, 16'hA55A};
        exp    = {160'h0, 16'hA55A};
        fork
            send_rx(8'h70, 1'b1, t0);
            begin
                repeat (157) @(negedge clk);
                packet = '1;
            end
        join
        wait_bytes(22, 4000, "frame1");
        check_frame(exp, "frame1");
        if (start_q.size() >= 22) begin
            chk("frame1_latency", 64'(start_q[0] - t0), 64'd156);
            chk("frame1_byte_spacing", 64'(start_q[1] - start_q[0]), 64'd160);
            chk("frame1_length", 64'(start_q[21] - start_q[0] + 160), 64'd3520);
        end
        chk("frame1_bit_width_err", 64'(width_err), 64'd0);
        repeat (600) @(negedge clk);
        chk("frame1_no_extra", 64'(rx_q.size()), 64'd22);

        // Second request during a frame is dropped.
        clear_mon();
        packet = pat;
        send_rx(8'h01, 1'b1, t0);
        send_rx(8'hFF, 1'b1, t0);
        wait_bytes(22, 4000, "frame2");
        check_frame(pat, "frame2");
        repeat (1000) @(negedge clk);
        chk("frame2_no_second_frame", 64'(rx_q.size()), 64'd22);
        chk("frame2_width_err", 64'(width_err), 64'd0);

        // Framing error and short glitch must not trigger.
        clear_mon();
        send_rx(8'h55, 1'b0, t0);
        repeat (500) @(negedge clk);
        chk("framing_err_no_frame", 64'(rx_q.size()) + 64'(start_q.size()), 64'd0);
        RxD = 1'b0;
        repeat (4) @(negedge clk);
        RxD = 1'b1;
        repeat (500) @(negedge clk);
        chk("glitch_no_frame", 64'(rx_q.size()) + 64'(start_q.size()), 64'd0);
        exp    = ~pat;
        packet = exp;
        send_rx(8'h3C, 1'b1, t0);
        wait_bytes(22, 4000, "recover");
        check_frame(exp, "recover");
        chk("recover_latency", 64'(start_q[0] - t0), 64'd156);

        // Reset mid byte 5 (all-zero packet, so the line is low there).
        repeat (300) @(negedge clk);
        clear_mon();
        packet = '0;
        send_rx(8'h11, 1'b1, t0);
        begin
            int k = 0;
            while (start_q.size() < 6 && k < 2000) begin
                @(negedge clk);
                k++;
            end
        end
        chk("rst_reached_byte5", 64'(start_q.size()), 64'd6);
        repeat (80) @(negedge clk);
        chk("pre_rst_txd_low", 64'(TxD), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_txd_next_cycle", 64'(TxD), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (400) @(negedge clk);
        clear_mon();
        repeat (400) @(negedge clk);
        chk("rst_no_resume", 64'(rx_q.size()) + 64'(start_q.size()), 64'd0);
        packet = pat;
        send_rx(8'h80, 1'b1, t0);
        wait_bytes(22, 4000, "post_rst");
        check_frame(pat, "post_rst");
        chk("post_rst_width_err", 64'(width_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
